// File: rtl/cpu_ask2_keyboard_ctrl.sv
// Avalon-MM keyboard controller: synchronise and debounce keys, queue press/release
// events in a FIFO popped through the DATA register, with a level IRQ while events wait.
module cpu_ask2_keyboard_ctrl #(
    parameter int unsigned KEYS            = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [KEYS-1:0] key_in,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            read,
    input  logic            write,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            irq
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [15:0] DbMax = 16'(DEBOUNCE_CYCLES - 1);

    logic [KEYS-1:0] sync1_q, sync2_q;
    logic [KEYS-1:0] stable_q, stable_d;
    logic [15:0]     db_cnt_q [KEYS];
    logic [15:0]     db_cnt_d [KEYS];
    logic [KEYS-1:0] pending_q, pending_d;
    logic [KEYS-1:0] ptype_q, ptype_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic [31:0]     readdata_q, readdata_d;
    logic            irq_q, irq_d;

    logic            found, push, pop, ovf_set, rd_en, wr_en;
    logic [KEYS-1:0] push_oh;
    logic [2:0]      push_idx;
    logic            push_type;
    logic [7:0]      push_byte;
    logic [31:0]     status;

    logic unused_wd;
    assign unused_wd = ^{writedata[31:9], writedata[7:2]};

    assign readdata = readdata_q;
    assign irq      = irq_q;

    always_comb begin
        rd_en = chipselect & read;
        wr_en = chipselect & write;

        // Lowest-index pending key wins the single push slot.
        found     = 1'b0;
        push_oh   = '0;
        push_idx  = '0;
        push_type = 1'b0;
        for (int k = 0; k < KEYS; k++) begin
            if (pending_q[k] && !found) begin
                found      = 1'b1;
                push_oh[k] = 1'b1;
                push_idx   = 3'(k);
                push_type  = ptype_q[k];
            end
        end
        push      = found & (count_q != CntW'(FIFO_DEPTH));
        push_byte = {push_type, 4'b0000, push_idx};
        pop       = rd_en & (address == 2'd0) & (count_q != '0);

        pending_d = pending_q;
        if (push) pending_d = pending_q & ~push_oh;

        stable_d = stable_q;
        ptype_d  = ptype_q;
        ovf_set  = 1'b0;
        for (int k = 0; k < KEYS; k++) begin
            db_cnt_d[k] = db_cnt_q[k];
            if (sync2_q[k] == stable_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (db_cnt_q[k] == DbMax) begin
                stable_d[k] = sync2_q[k];
                db_cnt_d[k] = '0;
                if (sync2_q[k] || ctrl_q[1]) begin
                    // A key just pushed this cycle frees its slot, so no collision.
                    if (pending_q[k] && !(push && push_oh[k])) ovf_set = 1'b1;
                    pending_d[k] = 1'b1;
                    ptype_d[k]   = sync2_q[k];
                end
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + 16'd1;
            end
        end

        wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q + CntW'(push) - CntW'(pop);

        ovf_d = ovf_q;
        if (wr_en && address == 2'd1 && writedata[8]) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;

        ctrl_d = ctrl_q;
        if (wr_en && address == 2'd2) ctrl_d = writedata[1:0];

        status            = '0;
        status[CntW-1:0]  = count_q;
        status[8]         = ovf_q;
        status[16+:KEYS]  = stable_q;

        readdata_d = '0;
        if (rd_en) begin
            unique case (address)
                2'd0: if (count_q != '0) readdata_d = {1'b1, 23'b0, mem_q[rptr_q]};
                2'd1: readdata_d = status;
                2'd2: readdata_d = {30'b0, ctrl_q};
                default: readdata_d = '0;
            endcase
        end

        irq_d = ctrl_d[0] & (count_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            pending_q  <= '0;
            ptype_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            ctrl_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int k = 0; k < KEYS; k++) db_cnt_q[k] <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q    <= key_in;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            pending_q  <= pending_d;
            ptype_q    <= ptype_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            ctrl_q     <= ctrl_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int k = 0; k < KEYS; k++) db_cnt_q[k] <= db_cnt_d[k];
            if (push) mem_q[wptr_q] <= push_byte;
        end
    end

endmodule

// File: tb/tb_cpu_ask2_keyboard_ctrl.sv
// Directed bench for cpu_ask2_keyboard_ctrl with a scoreboard of expected event bytes.
module tb_cpu_ask2_keyboard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  key_in = '0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  sb[$];

    cpu_ask2_keyboard_ctrl #(
        .KEYS           (6),
        .DEBOUNCE_CYCLES(16),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_in    (key_in),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        read_reg(a, d);
        check(tag, d, exp);
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d, exp;
        exp = '0;
        if (sb.size() > 0) exp = {1'b1, 23'b0, sb.pop_front()};
        read_reg(2'd0, d);
        check(tag, d, exp);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles from a key edge (driven at negedge) until irq rises, bounded at 40.
    task automatic irq_latency(output int c);
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!irq && c < 40);
    endtask

    initial begin
        int c;
        logic [31:0] d;

        // Reset state
        settle(3);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        check_reg("reset_status", 2'd1, 32'h0);
        check_reg("reset_ctrl", 2'd2, 32'h0);

        // 1: bounce on key2, then a clean press
        write_reg(2'd2, 32'h1);
        for (int i = 0; i < 20; i++) begin
            key_in[2] = ~key_in[2];
            settle(5);
        end
        key_in[2] = 1'b1;
        irq_latency(c);
        check("bounce_latency", c, 19);
        sb.push_back(8'h82);
        settle(4);
        check_reg("bounce_status", 2'd1, 32'h0004_0001);
        pop_check("bounce_pop");

        // 2: simultaneous press of keys 0 and 5 (key2 release filtered)
        key_in[2] = 1'b0;
        settle(25);
        check_reg("release_filtered", 2'd1, 32'h0);
        key_in[0] = 1'b1; key_in[5] = 1'b1;
        sb.push_back(8'h80); sb.push_back(8'h85);
        settle(25);
        check_reg("simul_status", 2'd1, 32'h0021_0002);
        pop_check("simul_pop0");
        pop_check("simul_pop1");

        // 3: fill, hold pending, collision overflow
        write_reg(2'd2, 32'h3);
        key_in[0] = 1'b0; key_in[5] = 1'b0;
        sb.push_back(8'h00); sb.push_back(8'h05);
        settle(25);
        key_in[4:1] = 4'hF;
        sb.push_back(8'h81); sb.push_back(8'h82); sb.push_back(8'h83); sb.push_back(8'h84);
        settle(25);
        key_in[0] = 1'b1; key_in[5] = 1'b1;
        sb.push_back(8'h80); sb.push_back(8'h85);
        settle(25);
        check_reg("full_status", 2'd1, 32'h003F_0008);
        key_in[1] = 1'b0;
        settle(25);
        check_reg("full_pending", 2'd1, 32'h003D_0008);
        key_in[1] = 1'b1;
        settle(25);
        check_reg("overflow_set", 2'd1, 32'h003F_0108);
        pop_check("full_pop");
        sb.push_back(8'h81);
        settle(3);
        check_reg("refill_count", 2'd1, 32'h003F_0108);
        write_reg(2'd1, 32'h100);
        check_reg("overflow_clear", 2'd1, 32'h003F_0008);
        for (int i = 0; i < 8; i++) pop_check("drain_pop");
        pop_check("drain_empty");

        // 4: release filter
        write_reg(2'd2, 32'h1);
        key_in = '0;
        settle(25);
        check_reg("filter_all_released", 2'd1, 32'h0);
        key_in[3] = 1'b1; settle(25);
        key_in[3] = 1'b0; settle(25);
        sb.push_back(8'h83);
        check_reg("filter_count", 2'd1, 32'h1);
        pop_check("filter_pop");
        write_reg(2'd2, 32'h3);
        key_in[3] = 1'b1; settle(25);
        key_in[3] = 1'b0; settle(25);
        sb.push_back(8'h83); sb.push_back(8'h03);
        check_reg("release_en_count", 2'd1, 32'h2);
        pop_check("release_en_pop0");
        pop_check("release_en_pop1");

        // 5: IRQ and readout
        write_reg(2'd2, 32'h1);
        check_reg("ctrl_readback", 2'd2, 32'h1);
        write_reg(2'd3, 32'hFFFF_FFFF);
        check_reg("reserved_read", 2'd3, 32'h0);
        check("irq_idle", {31'b0, irq}, 32'h0);
        @(negedge clk);
        key_in[1] = 1'b1;
        irq_latency(c);
        check("irq_latency", c, 19);
        sb.push_back(8'h81);
        pop_check("irq_pop");
        check("irq_after_pop", {31'b0, irq}, 32'h0);
        pop_check("irq_empty_read");

        // 6: reset mid-debounce with a read in flight
        write_reg(2'd2, 32'h3);
        key_in[4:2] = 3'b111;
        settle(25);
        check_reg("pre_reset_status", 2'd1, 32'h001E_0003);
        key_in[0] = 1'b1;
        settle(9);
        chipselect = 1'b1; read = 1'b1; address = 2'd1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        key_in = '0;
        chipselect = 1'b0; read = 1'b0;
        #1;
        check("mid_reset_readdata", readdata, 32'h0);
        check("mid_reset_irq", {31'b0, irq}, 32'h0);
        settle(3);
        reset_n = 1'b1;
        sb.delete();
        check_reg("post_reset_status", 2'd1, 32'h0);
        check_reg("post_reset_ctrl", 2'd2, 32'h0);
        settle(40);
        check_reg("post_reset_quiet", 2'd1, 32'h0);
        read_reg(2'd0, d);
        check("post_reset_data", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
